// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default geometry and address-field helpers.
package cache_pkg;

  localparam int unsigned DefNumSets      = 32;
  localparam int unsigned DefWordsPerLine = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2
  } cache_state_e;

  function automatic int unsigned off_width(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Lowest address bit of the set index.
  function automatic int unsigned idx_lsb(input int unsigned words_per_line);
    return 2 + $clog2(words_per_line);
  endfunction

  // Lowest address bit of the tag.
  function automatic int unsigned tag_lsb(input int unsigned num_sets,
                                          input int unsigned words_per_line);
    return 2 + $clog2(words_per_line) + $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned num_sets,
                                            input int unsigned words_per_line);
    return addr_w - tag_lsb(num_sets, words_per_line);
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tag store for icache_dm: combinational lookup/compare, line
// validation on fill completion and whole-cache invalidation.
module icache_tag_array
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS       = DefNumSets,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine,
  parameter int unsigned ADDR_W         = 32,
  localparam int unsigned IDX_W = idx_width(NUM_SETS),
  localparam int unsigned TAG_W = tag_width(ADDR_W, NUM_SETS, WORDS_PER_LINE)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_lookup_idx,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_match,
  input  logic             i_fill_we,
  input  logic             i_fill_set_valid,
  input  logic [IDX_W-1:0] i_fill_idx,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic             i_clear_all
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  assign o_match = valid_q[i_lookup_idx] && (tag_q[i_lookup_idx] == i_lookup_tag);

  // Invalidation wins over a same-cycle fill so a pending flush leaves the new line invalid.
  always_comb begin
    valid_d = valid_q;
    if (i_clear_all) begin
      valid_d = '0;
    end else if (i_fill_we && i_fill_set_valid) begin
      valid_d[i_fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_fill_we) begin
      tag_q[i_fill_idx] <= i_fill_tag;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with line refill over a request/beat
// handshake. Define ICACHE_PERF_EN to add hit/miss performance counters.
module icache_dm
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS       = DefNumSets,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_ren,
  input  logic              i_flush,
  output logic [31:0]       o_rdata,
  output logic              o_stall,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [31:0]       i_mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  localparam int unsigned OFF_W   = off_width(WORDS_PER_LINE);
  localparam int unsigned IDX_W   = idx_width(NUM_SETS);
  localparam int unsigned TAG_W   = tag_width(ADDR_W, NUM_SETS, WORDS_PER_LINE);
  localparam int unsigned IDX_LSB = idx_lsb(WORDS_PER_LINE);
  localparam int unsigned TAG_LSB = tag_lsb(NUM_SETS, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LastBeat = OFF_W'(WORDS_PER_LINE - 1);

  cache_state_e      state_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [OFF_W-1:0]  cnt_q;
  logic              flush_pend_q;
  logic              mem_ren_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              tag_match, hit, miss;
  logic              beat, last_beat, pend_now, clear_all;

  logic [31:0] data_q [NUM_SETS][WORDS_PER_LINE];

  assign req_off = i_req_addr[IDX_LSB-1:2];
  assign req_idx = i_req_addr[TAG_LSB-1:IDX_LSB];
  assign req_tag = i_req_addr[ADDR_W-1:TAG_LSB];

  // A flush in IDLE forces a miss so the request never sees a line being invalidated.
  assign hit  = i_req_ren && tag_match && (state_q == StIdle) && !i_flush;
  assign miss = i_req_ren && (state_q == StIdle) && !hit;

  assign o_stall    = (state_q != StIdle) || (i_req_ren && !hit);
  assign o_rdata    = data_q[req_idx][req_off];
  assign o_mem_ren  = mem_ren_q;
  assign o_mem_addr = mem_addr_q;

  assign beat      = (state_q == StFill) && i_mem_valid;
  assign last_beat = beat && (cnt_q == LastBeat);
  assign pend_now  = flush_pend_q || i_flush;
  assign clear_all = ((state_q == StIdle) && i_flush) || (last_beat && pend_now);

  icache_tag_array #(
    .NUM_SETS      (NUM_SETS),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .ADDR_W        (ADDR_W)
  ) u_tag_array (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_lookup_idx    (req_idx),
    .i_lookup_tag    (req_tag),
    .o_match         (tag_match),
    .i_fill_we       (last_beat),
    .i_fill_set_valid(!pend_now),
    .i_fill_idx      (fill_idx_q),
    .i_fill_tag      (fill_tag_q),
    .i_clear_all     (clear_all)
  );

  always_ff @(posedge i_clk) begin
    if (beat) begin
      data_q[fill_idx_q][cnt_q] <= i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss) begin
            fill_idx_q   <= req_idx;
            fill_tag_q   <= req_tag;
            mem_addr_q   <= {i_req_addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
            mem_ren_q    <= 1'b1;
            flush_pend_q <= 1'b0;
            state_q      <= StReq;
          end
        end
        StReq: begin
          cnt_q <= '0;
          if (i_flush) begin
            flush_pend_q <= 1'b1;
          end
          if (i_mem_ready) begin
            mem_ren_q <= 1'b0;
            state_q   <= StFill;
          end
        end
        StFill: begin
          if (i_flush) begin
            flush_pend_q <= 1'b1;
          end
          if (beat) begin
            cnt_q <= cnt_q + OFF_W'(1);
            if (last_beat) begin
              cnt_q        <= '0;
              flush_pend_q <= 1'b0;
              state_q      <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule
